// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared encodings and widths for the CPU clock-enable controller.
// State encoding is visible on the state output port.
package cpu_clk_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_clk_ctrl_tick_gen.sv
// tick_gen: periodic tick at DIV_SLOW or DIV_FAST clk cycles while enabled.
// Counter holds at 0 when disabled and restarts when speed_sel changes.
module tick_gen #(
  parameter int DIV_SLOW = 300_000,
  parameter int DIV_FAST = 3_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic speed_sel,
  output logic tick
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;
  logic          spd_q, spd_d;
  logic          spd_chg;

  // Terminal count for the currently selected period
  always_comb begin
    last = speed_sel ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
  end

  assign spd_chg = (speed_sel != spd_q);
  assign tick    = en && (cnt_q == last);

  // Count while enabled; clear when idle, on speed change or after a tick
  always_comb begin
    spd_d = speed_sel;
    cnt_d = cnt_q + CW'(1);
    if (!en || spd_chg || tick) begin
      cnt_d = '0;
    end
  end

  // Counter and registered speed copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      spd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spd_q <= spd_d;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt controller producing a one-cycle cpu_en pulse.
// Step button is synchronized, debounced and edge-detected inline.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_SLOW  = 300_000,
  parameter int DIV_FAST  = 3_000,
  parameter int DB_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_sw,
  input  logic               speed_sel,
  input  logic               step_btn,
  input  logic               halt,
  input  logic               resume,
  output logic               cpu_en,
  output logic               tick_led,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             step_q, step_d;
  logic             cpu_en_q, cpu_en_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  tick_gen #(
    .DIV_SLOW (DIV_SLOW),
    .DIV_FAST (DIV_FAST)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_RUN),
    .speed_sel (speed_sel),
    .tick      (tick)
  );

  // Synchronize, debounce and detect the rising edge of the step button
  always_comb begin
    sync1_d  = step_btn;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
    db_dly_d = db_q;
    step_d   = db_q & ~db_dly_q;
  end

  // Next state in priority order; unreachable encodings fall back to PAUSE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: begin
        if (halt)        state_d = ST_HALTED;
        else if (run_sw) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt)         state_d = ST_HALTED;
        else if (!run_sw) state_d = ST_PAUSE;
      end
      ST_HALTED: begin
        if (resume && !halt) state_d = ST_PAUSE;
      end
      default: state_d = ST_PAUSE;
    endcase
  end

  // Enable pulse, pulse counter and LED toggle
  always_comb begin
    cpu_en_d = !halt &&
               ((state_q == ST_RUN && run_sw && tick) ||
                (state_q == ST_PAUSE && step_q));
    cnt_d    = cnt_q;
    led_d    = led_q;
    if (cpu_en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      led_d = ~led_q;
    end
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PAUSE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= '0;
      step_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      led_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      db_cnt_q <= db_cnt_d;
      step_q   <= step_d;
      cpu_en_q <= cpu_en_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign tick_led  = led_q;
  assign state     = state_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/step/halt controller for the CPU's clock enable. It replaces a free-running divided clock with a single-cycle `cpu_en` pulse on the system clock. The pulse is issued either periodically at one of two selectable rates (RUN), or once per debounced step-button press (PAUSE). Issuing stops when the CPU raises `halt`. The block sits between the board clock/switches and the CPU core; all CPU state registers qualify their updates with `cpu_en`.

## Interface
Parameters:
- `DIV_SLOW`, 300_000 — `cpu_en` period in clk cycles when `speed_sel=0`; must be ≥2.
- `DIV_FAST`, 3_000 — `cpu_en` period in clk cycles when `speed_sel=1`; must be ≥2.
- `DB_CYCLES`, 100_000 — consecutive stable cycles required to accept a step-button level change; must be ≥1.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst` in 1 — asynchronous, active-high reset.
- `run_sw` in 1 — level input, synchronous: 1 requests continuous run.
- `speed_sel` in 1 — level input, synchronous: period select (0 = slow, 1 = fast).
- `step_btn` in 1 — raw asynchronous push button.
- `halt` in 1 — CPU halt request, synchronous to clk, level.
- `resume` in 1 — synchronous single-cycle pulse that leaves HALTED.
- `cpu_en` out 1 — registered CPU clock-enable pulse, one clk wide.
- `tick_led` out 1 — toggles on every `cpu_en` pulse.
- `state` out 2 — current FSM state: 0 = PAUSE, 1 = RUN, 2 = HALTED.
- `cycle_cnt` out 32 — number of `cpu_en` pulses issued since reset.

## Operation
- Reset values: `state`=PAUSE, `cpu_en`=0, `tick_led`=0, `cycle_cnt`=0, tick counter=0, synchronizer flops=0, debounced level=0.
- FSM transitions, evaluated every cycle in priority order:
  - PAUSE or RUN with `halt`=1 → HALTED.
  - PAUSE with `run_sw`=1 → RUN.
  - RUN with `run_sw`=0 → PAUSE.
  - HALTED with `resume`=1 and `halt`=0 → PAUSE.
  - `resume` while `halt`=1 is ignored.
  - Value 3 on `state` is unreachable; if it occurs, recover to PAUSE.
- Tick generator:
  - Counts 0..DIV−1 only while `state`=RUN and is held at 0 in any other state.
  - Asserts `tick` in the cycle where the count equals DIV−1, then wraps to 0.
  - DIV = `speed_sel` ? DIV_FAST : DIV_SLOW.
  - A change of `speed_sel`, detected against a registered copy, clears the counter to 0 on the next cycle.
- Step path:
  - `step_btn` passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes once the synchronized value has differed from it for DB_CYCLES consecutive cycles.
  - A rising edge of the debounced level is a `step` event.
- `cpu_en` next-value: `halt`=0 and ((`state`=RUN and `tick`) or (`state`=PAUSE and `step`)).
  - `halt`=1 suppresses a coincident tick or step.
  - Steps in RUN or HALTED are discarded, not queued.
- When `cpu_en`=1: `cycle_cnt` increments by 1 (modulo 2^32; 0xFFFF_FFFF wraps to 0) and `tick_led` toggles, both on the following edge.

## Timing
- RUN entry: if `state` becomes RUN at edge t, the first `cpu_en` is high in cycle t+DIV. After that, `cpu_en` pulses exactly every DIV cycles while RUN is held.
- Leaving RUN: no `cpu_en` in any cycle after the edge that leaves RUN. Re-entry restarts the full DIV count.
- Step latency: if `step_btn` is first sampled high at edge s and held, `cpu_en` is high in cycle s+DB_CYCLES+3. A release followed by a re-press needs a debounced fall first.
- Halt: `halt` high in cycle h gives `state`=HALTED from h+1. `cpu_en` is never high in cycle h+1 or later until PAUSE/RUN is re-entered.
- `cycle_cnt` and `tick_led` update one cycle after the `cpu_en` pulse.
- `rst` asserted mid-pulse or mid-debounce clears all state immediately. The output after deassertion is identical to power-up.

## Structure
- Shared package/header `cpu_clk_pkg`: state encodings `ST_PAUSE`/`ST_RUN`/`ST_HALTED`, state width, and the `cycle_cnt` width constant.
- Sub-module `tick_gen` (parameters DIV_SLOW, DIV_FAST; inputs clk, rst, en, speed_sel; output tick). It holds the counter and the speed-change clear.
- Debouncer and FSM stay inline in `cpu_clk_ctrl`.

## Test plan
All scenarios use DIV_SLOW=8, DIV_FAST=4, DB_CYCLES=4.
- Reset, then `run_sw`=1 at edge 10 (`state`=RUN at edge 11) → `cpu_en` in cycles 19, 27, 35; `cycle_cnt`=3 at edge 36; `tick_led`=1.
- RUN with `speed_sel` switched 0→1 mid-count → counter clears; `cpu_en` pulses 4 cycles apart afterwards, with no double pulse.
- PAUSE, `step_btn` high from edge 20 for 10 cycles, with glitches shorter than 4 cycles beforehand → exactly one `cpu_en` in cycle 27; glitches produce none.
- RUN, `halt`=1 in the same cycle `tick`=1 → no `cpu_en`; `state`=2 next cycle; `resume` with `halt`=1 is ignored; after `halt`=0, `resume` → `state`=0.
- Preload near wrap: 0xFFFF_FFFF pulses via fast force, then one more step → `cycle_cnt`=0.
- Assert `rst` for 1 cycle mid-RUN → all outputs 0 and `state`=PAUSE immediately; the first pulse after re-entering RUN arrives a full DIV later.
